// File: rtl/mvma_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the MVMA sequencer and its layer datapath.
// The master side is the sequencer; the slave side is the stream source/sink plus datapath.
interface mvma_seq_ctrl_if #(
   parameter int LOGM = 3,
   parameter int LOGN = 3
);
   logic                 s_valid;
   logic                 s_ready;
   logic                 m_valid;
   logic                 m_ready;
   logic                 wr_en_x;
   logic [LOGN-1:0]      addr_x;
   logic [LOGM+LOGN-1:0] addr_w;
   logic [LOGM-1:0]      addr_b;
   logic                 load_bias;
   logic                 mac_en;
   logic                 store_en;
   logic                 relu_en;
   logic [LOGM-1:0]      out_index;

   modport master (
      input  s_valid, m_ready,
      output s_ready, m_valid, wr_en_x, addr_x, addr_w, addr_b,
             load_bias, mac_en, store_en, relu_en, out_index
   );

   modport slave (
      output s_valid, m_ready,
      input  s_ready, m_valid, wr_en_x, addr_x, addr_w, addr_b,
             load_bias, mac_en, store_en, relu_en, out_index
   );
endinterface

// File: rtl/mvma_seq_ctrl.sv
// Sequencer for an M x N matrix-vector-multiply-accumulate layer: loads N inputs,
// walks the weight/bias ROMs row by row and hands out M results over a valid/ready stream.
module mvma_seq_ctrl #(
   parameter int M    = 8,
   parameter int N    = 8,
   parameter int LOGM = 3,
   parameter int LOGN = 3,
   parameter int RELU = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   mvma_seq_ctrl_if.master      bus
);

   localparam int AW = LOGM + LOGN;
   localparam int PW = $clog2(N + 3);

   typedef enum logic [2:0] {
      LOAD    = 3'd0,
      COMPUTE = 3'd1,
      DRAIN   = 3'd2,
      FINAL   = 3'd3,
      OUT     = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   phase;
   logic [LOGN-1:0] addr_x_q;
   logic [AW-1:0]   addr_w_q;
   logic [LOGM-1:0] row;
   logic            load_bias_q;
   logic            mac_en_q;
   logic            store_en_q;
   logic            relu_en_q;
   logic            s_ready_w;
   logic            m_valid_w;
   logic            s_fire;
   logic            m_fire;
   logic            last_x;
   logic            last_w;
   logic            last_row;

   assign s_ready_w = (state == LOAD);
   assign m_valid_w = (state == OUT);
   assign s_fire    = bus.s_valid & s_ready_w;
   assign m_fire    = m_valid_w & bus.m_ready;
   assign last_x    = (addr_x_q == LOGN'(N - 1));
   assign last_w    = (addr_w_q == AW'(M * N - 1));
   assign last_row  = (row == LOGM'(M - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // phase counts c0..c(N+2) of a row; COMPUTE covers the N MAC addresses,
   // DRAIN lets the ROM and multiplier pipeline empty, FINAL is the store cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (s_fire && last_x) state_nxt = COMPUTE;
         COMPUTE: if (phase == PW'(N - 1)) state_nxt = DRAIN;
         DRAIN:   if (phase == PW'(N + 1)) state_nxt = FINAL;
         FINAL:   state_nxt = OUT;
         OUT:     if (m_fire) state_nxt = last_row ? LOAD : COMPUTE;
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase       <= '0;
         addr_x_q    <= '0;
         addr_w_q    <= '0;
         row         <= '0;
         load_bias_q <= 1'b0;
         mac_en_q    <= 1'b0;
         store_en_q  <= 1'b0;
         relu_en_q   <= 1'b0;
      end else begin
         // Strobes are decoded one cycle early so they leave a flop, clean.
         load_bias_q <= (state == COMPUTE) && (phase == '0);
         mac_en_q    <= ((state == COMPUTE) || (state == DRAIN)) &&
                        (phase >= PW'(1)) && (phase <= PW'(N));
         store_en_q  <= (state == DRAIN) && (phase == PW'(N + 1));
         relu_en_q   <= (state == DRAIN) && (phase == PW'(N + 1)) && (RELU != 0);
         case (state)
            LOAD: begin
               phase <= '0;
               if (s_fire) addr_x_q <= last_x ? '0 : addr_x_q + LOGN'(1);
            end
            COMPUTE: begin
               phase    <= phase + PW'(1);
               addr_x_q <= last_x ? '0 : addr_x_q + LOGN'(1);
               addr_w_q <= last_w ? '0 : addr_w_q + AW'(1);
            end
            DRAIN, FINAL: begin
               phase <= phase + PW'(1);
            end
            OUT: begin
               phase <= '0;
               if (m_fire) begin
                  if (last_row) begin
                     row      <= '0;
                     addr_w_q <= '0;
                  end else begin
                     row <= row + LOGM'(1);
                  end
               end
            end
            default: begin
               phase <= '0;
            end
         endcase
      end
   end

   assign bus.s_ready   = s_ready_w;
   assign bus.m_valid   = m_valid_w;
   assign bus.wr_en_x   = s_fire;
   assign bus.addr_x    = addr_x_q;
   assign bus.addr_w    = addr_w_q;
   assign bus.addr_b    = row;
   assign bus.out_index = row;
   assign bus.load_bias = load_bias_q;
   assign bus.mac_en    = mac_en_q;
   assign bus.store_en  = store_en_q;
   assign bus.relu_en   = relu_en_q;

endmodule

// File: tb/tb_mvma_seq_ctrl.sv
// Bench for mvma_seq_ctrl: three instances (8x8 RELU=1, 8x8 RELU=0, 1x1) share one stimulus
// stream and are compared every cycle against a row/phase reference model.
module tb_mvma_seq_ctrl;

   localparam int NI = 3;
   localparam int PM [NI] = '{8, 8, 1};
   localparam int PN [NI] = '{8, 8, 1};
   localparam int PR [NI] = '{1, 0, 1};

   typedef enum int {MD_LOAD, MD_ROW, MD_OUT} mode_t;

   typedef struct {
      logic [31:0] s_ready;
      logic [31:0] m_valid;
      logic [31:0] wr_en_x;
      logic [31:0] addr_x;
      logic [31:0] addr_w;
      logic [31:0] addr_b;
      logic [31:0] out_index;
      logic [31:0] load_bias;
      logic [31:0] mac_en;
      logic [31:0] store_en;
      logic [31:0] relu_en;
   } sig_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic s_valid = 1'b0;
   logic m_ready = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   wr_seen = 0;

   mode_t md [NI];
   int    cnt [NI];
   int    row [NI];
   int    cyc [NI];

   mvma_seq_ctrl_if #(.LOGM(3), .LOGN(3)) bus_a ();
   mvma_seq_ctrl_if #(.LOGM(3), .LOGN(3)) bus_b ();
   mvma_seq_ctrl_if #(.LOGM(1), .LOGN(1)) bus_c ();

   assign bus_a.s_valid = s_valid;
   assign bus_a.m_ready = m_ready;
   assign bus_b.s_valid = s_valid;
   assign bus_b.m_ready = m_ready;
   assign bus_c.s_valid = s_valid;
   assign bus_c.m_ready = m_ready;

   mvma_seq_ctrl #(.M(8), .N(8), .LOGM(3), .LOGN(3), .RELU(1)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
   mvma_seq_ctrl #(.M(8), .N(8), .LOGM(3), .LOGN(3), .RELU(0)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
   mvma_seq_ctrl #(.M(1), .N(1), .LOGM(1), .LOGN(1), .RELU(1)) u_c (.clk(clk), .reset(reset), .bus(bus_c));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus_a.wr_en_x) wr_seen++;
   end

   function automatic sig_t observe(int i);
      sig_t o;
      case (i)
         0: begin
            o.s_ready = 32'(bus_a.s_ready);     o.m_valid = 32'(bus_a.m_valid);
            o.wr_en_x = 32'(bus_a.wr_en_x);     o.addr_x = 32'(bus_a.addr_x);
            o.addr_w = 32'(bus_a.addr_w);       o.addr_b = 32'(bus_a.addr_b);
            o.out_index = 32'(bus_a.out_index); o.load_bias = 32'(bus_a.load_bias);
            o.mac_en = 32'(bus_a.mac_en);       o.store_en = 32'(bus_a.store_en);
            o.relu_en = 32'(bus_a.relu_en);
         end
         1: begin
            o.s_ready = 32'(bus_b.s_ready);     o.m_valid = 32'(bus_b.m_valid);
            o.wr_en_x = 32'(bus_b.wr_en_x);     o.addr_x = 32'(bus_b.addr_x);
            o.addr_w = 32'(bus_b.addr_w);       o.addr_b = 32'(bus_b.addr_b);
            o.out_index = 32'(bus_b.out_index); o.load_bias = 32'(bus_b.load_bias);
            o.mac_en = 32'(bus_b.mac_en);       o.store_en = 32'(bus_b.store_en);
            o.relu_en = 32'(bus_b.relu_en);
         end
         default: begin
            o.s_ready = 32'(bus_c.s_ready);     o.m_valid = 32'(bus_c.m_valid);
            o.wr_en_x = 32'(bus_c.wr_en_x);     o.addr_x = 32'(bus_c.addr_x);
            o.addr_w = 32'(bus_c.addr_w);       o.addr_b = 32'(bus_c.addr_b);
            o.out_index = 32'(bus_c.out_index); o.load_bias = 32'(bus_c.load_bias);
            o.mac_en = 32'(bus_c.mac_en);       o.store_en = 32'(bus_c.store_en);
            o.relu_en = 32'(bus_c.relu_en);
         end
      endcase
      return o;
   endfunction

   // Expected outputs follow directly from the row timeline: c0..c(N-1) address the
   // operands, load_bias at c1, mac_en at c2..c(N+1), store at c(N+2), result at c(N+3).
   function automatic sig_t expect_sig(int i);
      sig_t e;
      int   mm = PM[i];
      int   nn = PN[i];
      int   c = cyc[i];
      int   next_w = ((row[i] + 1) * nn) % (mm * nn);
      e = '{default: 32'd0};
      case (md[i])
         MD_LOAD: begin
            e.s_ready = 32'd1;
            e.wr_en_x = 32'(s_valid);
            e.addr_x = 32'(cnt[i]);
         end
         MD_ROW: begin
            e.addr_b = 32'(row[i]);
            e.out_index = 32'(row[i]);
            e.addr_x = (c < nn) ? 32'(c) : 32'd0;
            e.addr_w = (c < nn) ? 32'(row[i] * nn + c) : 32'(next_w);
            e.load_bias = 32'(c == 1);
            e.mac_en = 32'((c >= 2) && (c <= nn + 1));
            e.store_en = 32'(c == nn + 2);
            e.relu_en = 32'((c == nn + 2) && (PR[i] != 0));
         end
         default: begin
            e.m_valid = 32'd1;
            e.addr_b = 32'(row[i]);
            e.out_index = 32'(row[i]);
            e.addr_w = 32'(next_w);
         end
      endcase
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         md[i] = MD_LOAD;
         cnt[i] = 0;
         row[i] = 0;
         cyc[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NI; i++) begin
         case (md[i])
            MD_LOAD: begin
               if (s_valid) begin
                  cnt[i]++;
                  if (cnt[i] == PN[i]) begin
                     md[i] = MD_ROW;
                     cnt[i] = 0;
                     row[i] = 0;
                     cyc[i] = 0;
                  end
               end
            end
            MD_ROW: begin
               cyc[i]++;
               if (cyc[i] == PN[i] + 3) md[i] = MD_OUT;
            end
            default: begin
               if (m_ready) begin
                  if (row[i] < PM[i] - 1) begin
                     row[i]++;
                     cyc[i] = 0;
                     md[i] = MD_ROW;
                  end else begin
                     row[i] = 0;
                     md[i] = MD_LOAD;
                  end
               end
            end
         endcase
      end
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(string tag);
      total++;
      bad++;
      $error("[TB] FAIL %s observed=timeout expected=event", tag);
   endtask

   task automatic check_output();
      sig_t o;
      sig_t e;
      for (int i = 0; i < NI; i++) begin
         o = observe(i);
         e = expect_sig(i);
         check($sformatf("u%0d.s_ready", i), o.s_ready, e.s_ready);
         check($sformatf("u%0d.m_valid", i), o.m_valid, e.m_valid);
         check($sformatf("u%0d.wr_en_x", i), o.wr_en_x, e.wr_en_x);
         check($sformatf("u%0d.addr_x", i), o.addr_x, e.addr_x);
         check($sformatf("u%0d.addr_w", i), o.addr_w, e.addr_w);
         check($sformatf("u%0d.addr_b", i), o.addr_b, e.addr_b);
         check($sformatf("u%0d.out_index", i), o.out_index, e.out_index);
         check($sformatf("u%0d.load_bias", i), o.load_bias, e.load_bias);
         check($sformatf("u%0d.mac_en", i), o.mac_en, e.mac_en);
         check($sformatf("u%0d.store_en", i), o.store_en, e.store_en);
         check($sformatf("u%0d.relu_en", i), o.relu_en, e.relu_en);
      end
   endtask

   task automatic apply_stimulus(logic sv, logic mr);
      s_valid = sv;
      m_ready = mr;
   endtask

   // One clock: the model advances on the edge the DUT samples, outputs are checked mid-cycle.
   task automatic tick();
      @(posedge clk);
      if (reset) model_step();
      @(negedge clk);
      check_output();
   endtask

   initial begin
      bit hit;
      model_reset();
      apply_stimulus(1'b0, 1'b0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_output();
      end
      reset = 1'b1;
      $display("[TB] reset released");
      repeat (2) tick();

      // Load one vector with s_valid low every other cycle, then keep offering a 9th sample.
      wr_seen = 0;
      for (int k = 0; k < 16; k++) begin
         apply_stimulus((k % 2) == 0, 1'b1);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b1, 1'b1);
         tick();
      end
      check("load.handshakes", 32'(wr_seen), 32'd8);

      // Run rows with m_ready high until row 2 starts, then stall its result.
      hit = 1'b0;
      for (int k = 0; k < 400 && !hit; k++) begin
         apply_stimulus(1'b0, 1'b1);
         tick();
         hit = (md[0] == MD_ROW) && (row[0] == 2);
      end
      if (!hit) timeout_fail("reach.row2");
      hit = 1'b0;
      for (int k = 0; k < 50 && !hit; k++) begin
         apply_stimulus(1'b0, 1'b0);
         tick();
         hit = (md[0] == MD_OUT);
      end
      if (!hit) timeout_fail("reach.out2");
      repeat (5) begin
         apply_stimulus(1'b0, 1'b0);
         tick();
      end
      check("hold.out_index", 32'(bus_a.out_index), 32'd2);

      // Finish the vector, then run a randomized stretch with a fresh vector.
      hit = 1'b0;
      for (int k = 0; k < 400 && !hit; k++) begin
         apply_stimulus(1'b0, 1'b1);
         tick();
         hit = (md[0] == MD_LOAD);
      end
      if (!hit) timeout_fail("reach.load");
      $display("[TB] end of vector reached, random phase");
      repeat (400) begin
         apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
         tick();
      end

      // Abort mid-row with reset and check that everything returns to idle at once.
      hit = 1'b0;
      for (int k = 0; k < 1500 && !hit; k++) begin
         apply_stimulus(1'($urandom_range(0, 1)), 1'b1);
         tick();
         hit = (md[0] == MD_ROW) && (row[0] == 4) && (cyc[0] == 5);
      end
      if (!hit) timeout_fail("reach.row4c5");
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_output();
      repeat (2) tick();
      reset = 1'b1;
      $display("[TB] restarted after mid-row reset");
      repeat (300) begin
         apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
